// File: rtl/ram_arbiter_if.sv
// Requester and RAM-port bundle for ram_arbiter.
// The slave modport is the arbiter's side; the master modport is the requesters plus the RAM.
interface ram_arbiter_if #(
    parameter int D_WIDTH = 8,
    parameter int A_WIDTH = 5
);
    logic               req0;
    logic               req1;
    logic               we0;
    logic               we1;
    logic [A_WIDTH-1:0] addr0;
    logic [A_WIDTH-1:0] addr1;
    logic [D_WIDTH-1:0] wdata0;
    logic [D_WIDTH-1:0] wdata1;
    logic               gnt0;
    logic               gnt1;
    logic               rvalid0;
    logic               rvalid1;
    logic [D_WIDTH-1:0] rdata;
    logic               ready;
    logic               ram_write_enable;
    logic [A_WIDTH-1:0] ram_address_write;
    logic [D_WIDTH-1:0] ram_data_write;
    logic [A_WIDTH-1:0] ram_address_read;
    logic [D_WIDTH-1:0] ram_data_read;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_data_read,
        output gnt0, gnt1, rvalid0, rvalid1, rdata, ready,
               ram_write_enable, ram_address_write, ram_data_write, ram_address_read
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_data_read,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata, ready,
               ram_write_enable, ram_address_write, ram_data_write, ram_address_read
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter in front of a dual-port (write/read) RAM.
// Optional macro RAM_ARB_CLEAR_EN adds a CLEAR state that zero-fills the RAM after reset.
module ram_arbiter #(
    parameter int D_WIDTH = 8,
    parameter int A_WIDTH = 5,
    parameter int A_MAX   = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    ram_arbiter_if.slave  bus
);

`ifdef RAM_ARB_CLEAR_EN
    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;
    localparam state_t RESET_STATE = ST_CLEAR;
    localparam logic [A_WIDTH-1:0] LAST_ADDR = A_WIDTH'(A_MAX - 1);
`else
    typedef enum logic [0:0] {
        ST_RUN = 1'b1
    } state_t;
    localparam state_t RESET_STATE = ST_RUN;
`endif

    // Static configuration guard: the word count must cover the whole address space.
    if (A_MAX != (1 << A_WIDTH)) begin : g_bad_amax
        $error("ram_arbiter: A_MAX must equal 2**A_WIDTH");
    end

    state_t             r_state;
    logic               r_prio;
    logic               r_we;
    logic [A_WIDTH-1:0] r_addr_w;
    logic [D_WIDTH-1:0] r_data_w;
    logic [A_WIDTH-1:0] r_addr_r;
    logic               r_rd_pend;
    logic               r_rd_own;
    logic               r_rvalid0;
    logic               r_rvalid1;
`ifdef RAM_ARB_CLEAR_EN
    logic [A_WIDTH-1:0] r_clr_cnt;
`endif

    logic               w_ready;
    logic               w_gnt0;
    logic               w_gnt1;
    logic               w_grant;
    logic               w_sel;
    logic               w_sel_we;
    logic [A_WIDTH-1:0] w_sel_addr;
    logic [D_WIDTH-1:0] w_sel_wdata;

    assign w_ready = (r_state == ST_RUN);

    // Grant decision; gated by rst_n so no grant leaks out while reset is held.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (rst_n && w_ready) begin
            if (bus.req0 && bus.req1) begin
                if (r_prio) begin
                    w_gnt1 = 1'b1;
                end else begin
                    w_gnt0 = 1'b1;
                end
            end else if (bus.req0) begin
                w_gnt0 = 1'b1;
            end else if (bus.req1) begin
                w_gnt1 = 1'b1;
            end else begin
                w_gnt0 = 1'b0;
                w_gnt1 = 1'b0;
            end
        end else begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
        end
    end

    assign w_grant = w_gnt0 | w_gnt1;
    assign w_sel   = w_gnt1;

    // Command mux selecting the granted requester's fields.
    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = {A_WIDTH{1'b0}};
        w_sel_wdata = {D_WIDTH{1'b0}};
        if (w_sel) begin
            w_sel_we    = bus.we1;
            w_sel_addr  = bus.addr1;
            w_sel_wdata = bus.wdata1;
        end else begin
            w_sel_we    = bus.we0;
            w_sel_addr  = bus.addr0;
            w_sel_wdata = bus.wdata0;
        end
    end

    // Control FSM, RAM port registers and the two-stage read owner/valid pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RESET_STATE;
            r_prio    <= 1'b0;
            r_we      <= 1'b0;
            r_addr_w  <= {A_WIDTH{1'b0}};
            r_data_w  <= {D_WIDTH{1'b0}};
            r_addr_r  <= {A_WIDTH{1'b0}};
            r_rd_pend <= 1'b0;
            r_rd_own  <= 1'b0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
`ifdef RAM_ARB_CLEAR_EN
            r_clr_cnt <= {A_WIDTH{1'b0}};
`endif
        end else begin
            r_rvalid0 <= r_rd_pend & ~r_rd_own;
            r_rvalid1 <= r_rd_pend & r_rd_own;
            case (r_state)
`ifdef RAM_ARB_CLEAR_EN
                ST_CLEAR: begin
                    r_we      <= 1'b1;
                    r_addr_w  <= r_clr_cnt;
                    r_data_w  <= {D_WIDTH{1'b0}};
                    r_rd_pend <= 1'b0;
                    r_clr_cnt <= r_clr_cnt + A_WIDTH'(1);
                    if (r_clr_cnt == LAST_ADDR) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_state <= ST_CLEAR;
                    end
                end
`endif
                ST_RUN: begin
                    r_rd_pend <= w_grant & ~w_sel_we;
                    r_rd_own  <= w_sel;
                    if (w_grant) begin
                        r_prio <= w_gnt0;
                        if (w_sel_we) begin
                            r_we     <= 1'b1;
                            r_addr_w <= w_sel_addr;
                            r_data_w <= w_sel_wdata;
                        end else begin
                            r_we     <= 1'b0;
                            r_addr_r <= w_sel_addr;
                        end
                    end else begin
                        r_we <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= RESET_STATE;
                    r_we      <= 1'b0;
                    r_rd_pend <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt0              = w_gnt0;
    assign bus.gnt1              = w_gnt1;
    assign bus.ready             = w_ready;
    assign bus.rvalid0           = r_rvalid0;
    assign bus.rvalid1           = r_rvalid1;
    assign bus.rdata             = bus.ram_data_read;
    assign bus.ram_write_enable  = r_we;
    assign bus.ram_address_write = r_addr_w;
    assign bus.ram_data_write    = r_data_w;
    assign bus.ram_address_read  = r_addr_r;

endmodule
